// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port (A3/WD3/WE3) between the
// single-cycle primary writeback path and a long-latency secondary writeback
// source. Secondary writes are buffered in a small FIFO and drained into
// cycles the primary leaves free. A starvation limiter forces the FIFO head
// onto the port after STARVE_MAX consecutive blocked cycles. Two hazard query
// ports report whether a queued secondary write still targets a register.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   p_valid/p_addr/p_data  primary write request
//   p_stall             primary not granted this cycle; hold the request
//   s_valid/s_addr/s_data  secondary write offer, accepted when s_ready
//   s_ready             FIFO not full
//   q1_addr/q2_addr     hazard query addresses
//   q1_busy/q2_busy     a queued secondary write targets the queried register
//   WE3/A3/WD3          register file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        p_valid,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    output logic        p_stall,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_addr,
    input  logic [31:0] s_data,
    input  logic [4:0]  q1_addr,
    input  logic [4:0]  q2_addr,
    output logic        q1_busy,
    output logic        q2_busy,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_PRI   = 2'd1,
        GNT_SEC   = 2'd2,
        GNT_FORCE = 2'd3
    } grant_t;

    // FIFO storage and bookkeeping
    logic [4:0]    r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;

    grant_t           w_grant;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid;
    logic [4:0]       w_head_addr;
    logic [31:0]      w_head_data;

    assign w_empty     = (r_count == {CW{1'b0}});
    assign s_ready     = (r_count != FULL_CNT);
    // $zero writes complete the handshake but are never stored.
    assign w_push      = s_valid & s_ready & (s_addr != 5'd0);
    assign w_pop       = (w_grant == GNT_FORCE) | (w_grant == GNT_SEC);
    assign w_head_addr = r_fifo_addr[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];
    // A forced secondary write only stalls a primary request that would write.
    assign p_stall     = (w_grant == GNT_FORCE) & p_valid & (p_addr != 5'd0);

    // Grant selection: forced secondary, then primary, then idle-port drain.
    always_comb begin
        w_grant = GNT_IDLE;
        if (!RST) begin
            w_grant = GNT_IDLE;
        end else if (!w_empty && (r_starve == STARVE_LIM)) begin
            w_grant = GNT_FORCE;
        end else if (p_valid && (p_addr != 5'd0)) begin
            w_grant = GNT_PRI;
        end else if (!w_empty) begin
            w_grant = GNT_SEC;
        end else begin
            w_grant = GNT_IDLE;
        end
    end

    // Write port mux driven by the grant.
    always_comb begin
        WE3 = 1'b0;
        A3  = 5'd0;
        WD3 = 32'd0;
        case (w_grant)
            GNT_FORCE, GNT_SEC: begin
                WE3 = 1'b1;
                A3  = w_head_addr;
                WD3 = w_head_data;
            end
            GNT_PRI: begin
                WE3 = 1'b1;
                A3  = p_addr;
                WD3 = p_data;
            end
            default: begin
                WE3 = 1'b0;
                A3  = 5'd0;
                WD3 = 32'd0;
            end
        endcase
    end

    // Entry i is valid when its distance from the read pointer is below count.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = ({1'b0, PW'(PW'(i) - r_rptr)} < r_count);
        end
    end

    // Hazard query over all valid entries, including a head being written now.
    always_comb begin
        q1_busy = 1'b0;
        q2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            q1_busy = q1_busy | (w_valid[i] & (r_fifo_addr[i] == q1_addr));
            q2_busy = q2_busy | (w_valid[i] & (r_fifo_addr[i] == q2_addr));
        end
        q1_busy = q1_busy & (q1_addr != 5'd0);
        q2_busy = q2_busy & (q2_addr != 5'd0);
    end

    // FIFO payload write; contents are qualified by the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= s_addr;
            r_fifo_data[r_wptr] <= s_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: counts primary wins over a waiting head, saturating.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if ((w_grant == GNT_PRI) && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Scoreboarded bench for regfile_wb_arbiter (DEPTH=4, STARVE_MAX=8).
// Primary requests and accepted secondary writes are queued when driven; a
// negedge monitor pops and compares them as they appear on the write port.
// Directed sequences cover reset, idle drain, priority/full, starvation,
// $zero handling and the hazard query.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        p_valid = 1'b0;
    logic [4:0]  p_addr  = 5'd0;
    logic [31:0] p_data  = 32'd0;
    logic        p_stall;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_addr  = 5'd0;
    logic [31:0] s_data  = 32'd0;
    logic [4:0]  q1_addr = 5'd0;
    logic [4:0]  q2_addr = 5'd0;
    logic        q1_busy;
    logic        q2_busy;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] sq[$];
    logic [36:0] pq[$];
    logic [36:0] mon_e;

    int s_stalls;
    int accepted;
    int stall_cnt;
    int stall_cy;
    logic granted;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .CLK(CLK), .RST(RST),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data), .p_stall(p_stall),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic p_set(input logic [4:0] a, input logic [31:0] d);
        p_valid = 1'b1;
        p_addr  = a;
        p_data  = d;
        if (a != 5'd0) pq.push_back({a, d});
    endtask

    // Scoreboard monitor: classify each port write and compare to the queues.
    always @(negedge CLK) begin
        if (RST) begin
            if (WE3) check_eq("a3_nonzero", {31'd0, (A3 == 5'd0)}, 32'd0);
            if (p_valid && (p_addr != 5'd0) && !p_stall) begin
                check_eq("pri_we3", {31'd0, WE3}, 32'd1);
                if (pq.size() == 0) begin
                    check_eq("pri_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = pq.pop_front();
                    check_eq("pri_a3", {27'd0, A3}, {27'd0, mon_e[36:32]});
                    check_eq("pri_wd3", WD3, mon_e[31:0]);
                end
            end else if (WE3) begin
                if (sq.size() == 0) begin
                    check_eq("sec_unexpected", {27'd0, A3}, 32'd0);
                end else begin
                    mon_e = sq.pop_front();
                    check_eq("sec_a3", {27'd0, A3}, {27'd0, mon_e[36:32]});
                    check_eq("sec_wd3", WD3, mon_e[31:0]);
                end
            end
            if (s_valid && s_ready && (s_addr != 5'd0)) sq.push_back({s_addr, s_data});
        end
    end

    initial begin
        // Reset values
        #12;
        check_eq("rst_we3", {31'd0, WE3}, 32'd0);
        check_eq("rst_a3", {27'd0, A3}, 32'd0);
        check_eq("rst_wd3", WD3, 32'd0);
        check_eq("rst_pstall", {31'd0, p_stall}, 32'd0);
        check_eq("rst_sready", {31'd0, s_ready}, 32'd1);
        check_eq("rst_q1busy", {31'd0, q1_busy}, 32'd0);
        next();
        RST = 1'b1;

        // Idle-port drain: r5 written in the cycle after acceptance
        next();
        s_valid = 1'b1; s_addr = 5'd5; s_data = 32'hAAAA_0001;
        mid();
        check_eq("b_sready", {31'd0, s_ready}, 32'd1);
        check_eq("b_pre_we3", {31'd0, WE3}, 32'd0);
        next();
        s_valid = 1'b0;
        mid();
        check_eq("b_we3", {31'd0, WE3}, 32'd1);
        check_eq("b_a3", {27'd0, A3}, 32'd5);
        check_eq("b_wd3", WD3, 32'hAAAA_0001);
        next();
        mid();
        check_eq("b_post_we3", {31'd0, WE3}, 32'd0);
        next();

        // Priority and full: primary every cycle while the FIFO fills
        for (int c = 0; c < 8; c++) begin
            p_set(5'(c + 1), 32'h1000_0000 + 32'(c));
            s_valid = 1'b1;
            if (c < 4) begin
                s_addr = 5'(20 + c); s_data = 32'h2000_0000 + 32'(c);
            end else begin
                s_addr = 5'd24; s_data = 32'h2000_0004;
            end
            mid();
            check_eq("c_pstall", {31'd0, p_stall}, 32'd0);
            check_eq("c_sready", {31'd0, s_ready}, (c < 4) ? 32'd1 : 32'd0);
            next();
        end
        p_valid = 1'b0;
        s_stalls = 4;
        accepted = 0;
        for (int t = 0; t < 20 && accepted == 0; t++) begin
            mid();
            if (s_ready) accepted = 1;
            else s_stalls++;
            next();
        end
        s_valid = 1'b0;
        check_eq("c_push5_accepted", 32'(accepted), 32'd1);
        check_eq("c_push5_stalls", 32'(s_stalls), 32'd5);
        repeat (8) next();
        check_eq("c_drained_sready", {31'd0, s_ready}, 32'd1);

        // Starvation: one queued entry under continuous primary traffic
        p_set(5'd2, 32'h5000_0000);
        s_valid = 1'b1; s_addr = 5'd9; s_data = 32'h9999_0009;
        stall_cnt = 0;
        stall_cy  = -1;
        for (int cy = 0; cy < 14; cy++) begin
            mid();
            granted = !p_stall;
            if (p_stall) begin
                stall_cnt++;
                stall_cy = cy;
                check_eq("d_force_a3", {27'd0, A3}, 32'd9);
            end
            next();
            s_valid = 1'b0;
            if (granted && cy < 13) p_set(5'(3 + cy % 8), 32'h5000_0001 + 32'(cy));
        end
        p_valid = 1'b0;
        check_eq("d_stall_count", 32'(stall_cnt), 32'd1);
        check_eq("d_stall_cycle", 32'(stall_cy), 32'd9);
        next();

        // $zero and hazards
        q1_addr = 5'd7; q2_addr = 5'd0;
        p_set(5'd3, 32'h3000_0000);
        s_valid = 1'b1; s_addr = 5'd0; s_data = 32'hDEAD_0000;
        mid();
        check_eq("e_r0_sready", {31'd0, s_ready}, 32'd1);
        check_eq("e_q1_c0", {31'd0, q1_busy}, 32'd0);
        next();
        p_set(5'd3, 32'h3000_0001);
        s_addr = 5'd7; s_data = 32'h7777_0007;
        mid();
        check_eq("e_q1_enq", {31'd0, q1_busy}, 32'd0);
        next();
        s_valid = 1'b0;
        p_set(5'd3, 32'h3000_0002);
        mid();
        check_eq("e_q1_c2", {31'd0, q1_busy}, 32'd1);
        check_eq("e_q2_c2", {31'd0, q2_busy}, 32'd0);
        next();
        p_set(5'd3, 32'h3000_0003);
        mid();
        check_eq("e_q1_c3", {31'd0, q1_busy}, 32'd1);
        next();
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hBAD0_0000;
        mid();
        check_eq("e_q1_head", {31'd0, q1_busy}, 32'd1);
        check_eq("e_r0p_pstall", {31'd0, p_stall}, 32'd0);
        check_eq("e_r0p_we3", {31'd0, WE3}, 32'd1);
        check_eq("e_r0p_a3", {27'd0, A3}, 32'd7);
        next();
        p_valid = 1'b0;
        mid();
        check_eq("e_q1_done", {31'd0, q1_busy}, 32'd0);
        check_eq("e_idle_we3", {31'd0, WE3}, 32'd0);
        next();

        // Reset mid-stream with three queued entries
        for (int c = 0; c < 3; c++) begin
            p_set(5'(1 + c), 32'h4000_0000 + 32'(c));
            s_valid = 1'b1; s_addr = 5'(10 + c); s_data = 32'h4400_0000 + 32'(c);
            mid();
            check_eq("a_pstall", {31'd0, p_stall}, 32'd0);
            next();
        end
        p_valid = 1'b0; s_valid = 1'b0;
        q1_addr = 5'd10; q2_addr = 5'd12;
        #1;
        check_eq("a_pre_q1", {31'd0, q1_busy}, 32'd1);
        check_eq("a_pre_q2", {31'd0, q2_busy}, 32'd1);
        check_eq("a_pre_sready", {31'd0, s_ready}, 32'd1);
        #1;
        RST = 1'b0;
        sq.delete();
        #1;
        check_eq("a_rst_we3", {31'd0, WE3}, 32'd0);
        check_eq("a_rst_sready", {31'd0, s_ready}, 32'd1);
        check_eq("a_rst_q1", {31'd0, q1_busy}, 32'd0);
        check_eq("a_rst_q2", {31'd0, q2_busy}, 32'd0);
        next();
        next();
        RST = 1'b1;
        for (int c = 0; c < 6; c++) begin
            mid();
            check_eq("a_no_replay_we3", {31'd0, WE3}, 32'd0);
            check_eq("a_no_replay_q1", {31'd0, q1_busy}, 32'd0);
            next();
        end

        check_eq("end_sq_empty", 32'(sq.size()), 32'd0);
        check_eq("end_pq_empty", 32'(pq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32x32 register file. The register file has a single write port (A3/WD3/WE3); this block shares it between the primary writeback path (single-cycle datapath, fixed priority) and a secondary long-latency writeback source (multiply/divide or load-return unit). Secondary writes are buffered in a small FIFO and drained into idle write-port cycles. A starvation limiter and a pending-write hazard query let the datapath keep register ordering correct.

## Interface
- DEPTH, 4: secondary FIFO entries; power of two, >= 2.
- STARVE_MAX, 8: consecutive blocked cycles before the secondary is forced onto the port; >= 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- p_valid  in  1  primary write request.
- p_addr  in  5  primary destination register.
- p_data  in  32  primary write data.
- p_stall  out  1  primary was not granted this cycle; hold p_valid/p_addr/p_data stable.
- s_valid  in  1  secondary write offered.
- s_ready  out  1  FIFO can accept (= not full).
- s_addr  in  5  secondary destination register.
- s_data  in  32  secondary write data.
- q1_addr, q2_addr  in  5 each  hazard query addresses (register file read addresses).
- q1_busy, q2_busy  out  1 each  a queued secondary write targets that register.
- WE3  out  1  register file write enable.
- A3  out  5  register file write address.
- WD3  out  32  register file write data.

## Operation
- State: FIFO storage (addr+data per entry), read/write pointers (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (0..DEPTH), starvation counter (0..STARVE_MAX).
- Enqueue: s_valid & s_ready at the edge stores {s_addr, s_data} at the write pointer. s_addr = 0 is accepted (handshake completes) but not stored; $zero is never written.
- s_ready = (count != DEPTH), combinational. Full with a simultaneous pop does not raise s_ready in that cycle.
- Grant, evaluated combinationally each cycle:
  - FORCE: FIFO non-empty and starve counter == STARVE_MAX. The secondary head is written and p_stall = p_valid.
  - PRIMARY: otherwise, p_valid and p_addr != 0. The primary is written.
  - SECONDARY: otherwise, FIFO non-empty. The head is written and popped at the edge.
  - IDLE: WE3 = 0, A3 = 0, WD3 = 0.
- A primary request to p_addr = 0 is dropped: no write, p_stall = 0, and the port counts as free for the secondary.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on cycles where the FIFO is non-empty and PRIMARY wins.
  - Clears on any secondary grant or when the FIFO is empty.
- Hazard query: qN_busy = 1 if any valid FIFO entry has addr == qN_addr. The head being written this cycle still counts as busy. An entry being enqueued this cycle does not. qN_addr = 0 always gives busy = 0.
- The block does not reorder or cancel writes. WAW/RAW ordering is the issuer's duty, using the q ports.

## Timing
- Reset (RST low, asynchronous):
  - FIFO empty, pointers 0, counters 0.
  - WE3 = 0, A3 = 0, WD3 = 0, p_stall = 0, s_ready = 1, q1_busy = q2_busy = 0.
  - Reset mid-drain discards all queued entries.
- Primary latency: 0 cycles combinational pass-through. The register file captures at the next edge.
- Secondary latency: an entry accepted at edge k drives WE3 in cycle k..k+1 at the earliest, so the register file is updated at edge k+1.
- Push and pop at the same edge: count unchanged, both pointers advance.
- Under a continuous primary stream, a secondary entry waits at most STARVE_MAX cycles at the FIFO head.
- All outputs are combinational from registered state plus the current inputs. There is no combinational path from s_valid to any output.

## Test plan
- Reset: RST low mid-stream with 3 queued entries. Required: WE3 = 0, s_ready = 1, q busy = 0 immediately. After release, no queued write ever appears.
- Idle-port drain: s writes r5 = 0xAAAA0001 at edge 0, no primary. Required: WE3 = 1, A3 = 5, WD3 = 0xAAAA0001 in cycle 0..1; the register file holds it after edge 1.
- Priority and full:
  - Primary valid every cycle (r1..r8) while 4 secondary writes are pushed.
  - Required: s_ready = 0 after 4 accepts. All primary writes land in order.
  - The 5th secondary push stalls until a pop.
- Starvation (STARVE_MAX = 8):
  - Continuous primary traffic with 1 queued entry.
  - Required: the forced secondary write happens on the 9th cycle. p_stall = 1 for exactly that cycle, then the held primary write completes.
- $zero and hazards:
  - Secondary writes r0 and r7. Required: r0 is never written; q1_addr = 7 gives busy = 1 until the edge completing that write; q2_addr = 0 gives busy = 0.
  - Primary write to r0 with the FIFO non-empty. Required: the secondary is granted that cycle with p_stall = 0.
